piso_serial_scheduler: RTL
==========================

// Module: piso_serial_scheduler
// PURPOSE
//   Shares one parallel-in/serial-out shift datapath between two word requesters.
//   Round-robin arbitration picks a requester and accepts its N-bit word with a
//   valid/ready handshake, then shifts it out MSB first with framing strobes.
//   Sits between parallel word producers and a single-wire serial link.
// PARAMETERS
//   N    8  word width in bits; N >= 2
//   GAP  1  idle cycles forced between words; 0 gives back-to-back frames
// PORTS
//   clk        in   1  clock, rising edge
//   rst        in   1  reset, asynchronous, active-high
//   req_data0  in   N  word from requester 0
//   req_valid0 in   1  requester 0 has a word
//   req_ready0 out  1  word 0 accepted this cycle (combinational)
//   req_data1  in   N  word from requester 1
//   req_valid1 in   1  requester 1 has a word
//   req_ready1 out  1  word 1 accepted this cycle (combinational)
//   so         out  1  serial data out, MSB first (registered)
//   so_valid   out  1  so carries a data bit
//   so_first   out  1  so is bit N-1 of the word
//   so_last    out  1  so is bit 0 of the word
//   so_src     out  1  index of the requester that owns the current bit
//   busy       out  1  state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE; so, so_valid, so_first, so_last, so_src and busy = 0;
//     bit counter = 0; gap counter = 0; last_grant = 1 (req 0 wins first tie).
//   - Reset mid-frame aborts the frame; the partial word is dropped, no retry.
//   - FSM states: IDLE, SHIFT, GAP.
//   - Accept window: state IDLE, or SHIFT on bit 0 when GAP == 0.
//   - Grant rule, applied in the accept window:
//     only one valid -> grant it; both valid -> grant !last_grant.
//     req_readyK = accept window && grant == K. Never both high.
//   - Handshake: a transfer occurs when req_validK && req_readyK at a rising edge.
//     Data is captured only on that edge. Requesters hold valid and data until ready.
//     A valid dropped before ready causes no transfer.
//   - On transfer: the shift reg loads the word, last_grant and so_src take K,
//     the bit counter clears, and state becomes SHIFT.
//   - Latency: bit N-1 appears on so in the cycle after the accept edge.
//   - SHIFT: so_valid = 1; so = the current MSB; the shift reg shifts left, filling with 0.
//     The counter increments each cycle. so_first = (count == 0). so_last = (count == N-1).
//   - End of SHIFT, on the so_last cycle:
//     if GAP > 0 -> GAP state with gap counter = GAP.
//     if GAP == 0 and a transfer occurs -> stay in SHIFT with the new word and no bubble.
//     otherwise -> IDLE.
//   - GAP: so_valid = 0 and so = 0; the counter decrements each cycle.
//     GAP is left for IDLE after exactly GAP cycles. Requests wait.
//   - Throughput: one word per N + GAP cycles. In IDLE each word also costs 1 accept cycle.
//   - so, so_first, so_last, so_src hold 0 whenever so_valid = 0.
// TESTING
//   1 N=8, GAP=1, req_data0=8'hA5 valid alone.
//     Expect req_ready0 high for 1 cycle, then so = 1,0,1,0,0,1,0,1.
//     Expect so_first on bit 1, so_last on bit 8, so_src = 0.
//   2 Both valid from reset, data0=8'hFF, data1=8'h00.
//     Expect req 0 served first, then req 1, with so_src = 0 then 1.
//     Both still valid -> grants alternate 0,1,0,1.
//   3 GAP=0, req1 valid continuously, 4 words.
//     Expect so_valid high for 32 consecutive cycles.
//     req_ready1 pulses on every so_last cycle; no idle bubble between words.
//   4 GAP=2: expect exactly 2 cycles of so_valid = 0 between so_last and the next accept cycle.
//     busy stays high through GAP.
//   5 Assert rst at bit 4 of a frame.
//     Expect all outputs 0 immediately (async), then state IDLE.
//     The next frame starts cleanly with so_first.
//   6 Pulse req_valid0 for 1 cycle while SHIFT is busy (GAP=1).
//     Expect no transfer, req_ready0 never high, and no extra frame.

Source files
------------

// File: rtl/piso_serial_scheduler.sv
// Two-requester round-robin front end feeding one MSB-first parallel-in/serial-out shifter.
// Each word is accepted with a valid/ready handshake and then framed by so_first/so_last strobes.
module piso_serial_scheduler #(
    parameter int N   = 8,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_data0,
    input  logic         req_valid0,
    output logic         req_ready0,
    input  logic [N-1:0] req_data1,
    input  logic         req_valid1,
    output logic         req_ready1,
    output logic         so,
    output logic         so_valid,
    output logic         so_first,
    output logic         so_last,
    output logic         so_src,
    output logic         busy
);

    localparam int CW        = $clog2(N);
    localparam int GW        = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam bit BACK2BACK = (GAP == 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [GW-1:0]  gap_cnt, gap_n;
    logic [N-1:0]   shreg, shreg_n;
    logic           last_grant, last_grant_n;

    logic           last_bit;
    logic           accept_win;
    logic           any_valid;
    logic           grant;
    logic           xfer;

    // Back-to-back mode reopens the accept window on the final bit so the next word follows without a bubble.
    assign last_bit   = (state == S_SHIFT) && (cnt == CW'(N - 1));
    assign accept_win = (state == S_IDLE) || (last_bit && BACK2BACK);
    assign any_valid  = req_valid0 | req_valid1;
    assign grant      = (req_valid0 && req_valid1) ? ~last_grant : req_valid1;
    assign xfer       = accept_win && any_valid;
    assign req_ready0 = xfer && !grant;
    assign req_ready1 = xfer && grant;
    assign busy       = (state != S_IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_n      = state;
        cnt_n        = cnt;
        gap_n        = gap_cnt;
        shreg_n      = shreg;
        last_grant_n = last_grant;
        case (state)
            S_IDLE: ;
            S_SHIFT: begin
                cnt_n   = cnt + CW'(1);
                shreg_n = {shreg[N-2:0], 1'b0};
                if (last_bit) begin
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gap_n   = GW'(GAP);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_n = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // An accepted word overrides the end-of-frame decision above.
        if (xfer) begin
            state_n      = S_SHIFT;
            cnt_n        = '0;
            shreg_n      = grant ? req_data1 : req_data0;
            last_grant_n = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            last_grant <= 1'b1;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            so_first   <= 1'b0;
            so_last    <= 1'b0;
            so_src     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_n;
            cnt        <= cnt_n;
            gap_cnt    <= gap_n;
            shreg      <= shreg_n;
            last_grant <= last_grant_n;
            so         <= (state_n == S_SHIFT) && shreg_n[N-1];
            so_valid   <= (state_n == S_SHIFT);
            so_first   <= (state_n == S_SHIFT) && (cnt_n == '0);
            so_last    <= (state_n == S_SHIFT) && (cnt_n == CW'(N - 1));
            so_src     <= (state_n == S_SHIFT) && last_grant_n;
        end
    end

endmodule
